// File: rtl/lookup_arbiter.sv
// Round-robin arbiter sharing one fixed-latency lookup table between NREQ requesters.
// A non-stalling tag pipeline routes each result back to its requester in grant order.
module lookup_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int LAT  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arb_en,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] addr,
   output logic [NREQ-1:0]    gnt,
   output logic               lk_en,
   output logic [AW-1:0]      lk_addr,
   input  logic [DW-1:0]      lk_data,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               busy
);
   localparam int PW = $clog2(NREQ);
   localparam logic [PW:0]   NREQ_X = (PW+1)'(NREQ);
   localparam logic [PW-1:0] LAST   = PW'(NREQ-1);

   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] sel_idx;
   logic          sel_found;
   logic [PW:0]   cand;
   logic          grant_ok;
   logic [AW-1:0] addr_arr [NREQ];

   logic [LAT:0]  tag_vld_reg;
   logic [PW-1:0] tag_idx_reg [LAT+1];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign addr_arr[gi] = addr[gi*AW +: AW];
         assign gnt[gi]      = grant_ok && (sel_idx == PW'(gi));
      end
   endgenerate

   // Search starts at ptr and wraps, so the most recent winner has lowest priority.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_reg} + (PW+1)'(k);
         if (cand >= NREQ_X) begin
            cand = cand - NREQ_X;
         end
         if (!sel_found && req[cand[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[PW-1:0];
         end
      end
   end

   assign grant_ok = sel_found && arb_en && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg     <= '0;
         lk_en       <= 1'b0;
         lk_addr     <= '0;
         tag_vld_reg <= '0;
         for (int s = 0; s <= LAT; s++) begin
            tag_idx_reg[s] <= '0;
         end
         rsp_valid   <= '0;
         rsp_data    <= '0;
      end else begin
         if (grant_ok) begin
            ptr_reg <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
            lk_addr <= addr_arr[sel_idx];
         end
         lk_en <= grant_ok;

         // Stage 0 lines up with lk_en; the last stage lines up with valid lk_data.
         tag_vld_reg    <= {tag_vld_reg[LAT-1:0], grant_ok};
         tag_idx_reg[0] <= sel_idx;
         for (int s = 1; s <= LAT; s++) begin
            tag_idx_reg[s] <= tag_idx_reg[s-1];
         end

         rsp_valid <= '0;
         if (tag_vld_reg[LAT]) begin
            rsp_valid[tag_idx_reg[LAT]] <= 1'b1;
            rsp_data                    <= lk_data;
         end
      end
   end

   assign busy = lk_en | (|tag_vld_reg) | (|rsp_valid);

endmodule

// File: tb/tb_lookup_arbiter.sv
// Bench for lookup_arbiter: table-driven grant vectors plus a response scoreboard,
// with a behavioural lookup table that returns addr ^ 8'hFF after LAT cycles.
module tb_lookup_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int LAT  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               arb_en = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*AW-1:0] addr = '0;
   logic [NREQ-1:0]    gnt;
   logic               lk_en;
   logic [AW-1:0]      lk_addr;
   logic [DW-1:0]      lk_data;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               busy;

   lookup_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .addr(addr), .gnt(gnt),
      .lk_en(lk_en), .lk_addr(lk_addr), .lk_data(lk_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Lookup table model: data for the address presented in cycle c appears in cycle c+LAT.
   logic [DW-1:0] lk_pipe [LAT];
   always @(posedge clk) begin
      lk_pipe[0] <= lk_addr ^ 8'hFF;
      for (int k = 1; k < LAT; k++) begin
         lk_pipe[k] <= lk_pipe[k-1];
      end
   end
   assign lk_data = lk_pipe[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [NREQ-1:0] r;
      logic            a;
      logic [NREQ-1:0] eg;
   } vec_t;
   vec_t tbl[$];

   logic          exp_lk_en = 1'b0;
   logic [AW-1:0] exp_lk_addr = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, expv);
      end
   endtask

   function automatic logic [NREQ*AW-1:0] mkaddr(input int c);
      logic [NREQ*AW-1:0] v;
      for (int i = 0; i < NREQ; i++) begin
         v[i*AW +: AW] = AW'(c*29 + i*64 + 7);
      end
      return v;
   endfunction

   // One clock cycle: drive inputs, sample mid-cycle, check everything, step to next cycle.
   task automatic tick(input logic r_rst, input logic [NREQ-1:0] r, input logic a,
                       input logic [NREQ*AW-1:0] ad, input logic [NREQ-1:0] eg, input string nm);
      exp_t            e;
      int              idx;
      logic            exp_busy;
      logic [NREQ-1:0] oh;
      rst = r_rst;
      if (r_rst) begin
         sb.delete();
         exp_lk_en   = 1'b0;
         exp_lk_addr = '0;
      end
      req = r; arb_en = a; addr = ad;
      #4;
      exp_busy = (sb.size() > 0);
      chk({nm, ":gnt"}, 32'(gnt), 32'(eg));
      chk({nm, ":lk_en"}, 32'(lk_en), 32'(exp_lk_en));
      chk({nm, ":lk_addr"}, 32'(lk_addr), 32'(exp_lk_addr));
      chk({nm, ":busy"}, 32'(busy), 32'(exp_busy));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e  = sb.pop_front();
         oh = NREQ'(1) << e.idx;
         chk({nm, ":rsp_valid"}, 32'(rsp_valid), 32'(oh));
         chk({nm, ":rsp_data"}, 32'(rsp_data), 32'(e.data));
         $display("rsp cyc=%0d req=%0d data=%02h", cyc, e.idx, rsp_data);
      end else begin
         chk({nm, ":rsp_idle"}, 32'(rsp_valid), 32'(0));
      end
      if (eg != '0) begin
         idx = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) idx = i;
         end
         e.idx  = idx;
         e.data = ad[idx*AW +: AW] ^ 8'hFF;
         e.due  = cyc + LAT + 2;
         sb.push_back(e);
         exp_lk_en   = 1'b1;
         exp_lk_addr = ad[idx*AW +: AW];
      end else begin
         exp_lk_en = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [NREQ-1:0] r, input logic a, input logic [NREQ-1:0] eg);
      vec_t v;
      v.r = r; v.a = a; v.eg = eg;
      tbl.push_back(v);
   endtask

   initial begin
      logic [NREQ*AW-1:0] ad;

      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) tick(1'b1, '0, 1'b1, '0, '0, "reset");
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, '0, '0, "idle");

      ad = '0;
      ad[1*AW +: AW] = 8'h3C;
      tick(1'b0, 4'b0010, 1'b1, ad, 4'b0010, "single");
      for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, '0, '0, "single_drain");

      // Return ptr to 0 before the rotation vectors.
      tick(1'b1, '0, 1'b1, '0, '0, "reset2");

      // Full rotation from ptr=0.
      add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0010);
      add(4'b1111, 1'b1, 4'b0100); add(4'b1111, 1'b1, 4'b1000);
      add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0010);
      add(4'b1111, 1'b1, 4'b0100); add(4'b1111, 1'b1, 4'b1000);
      // Wrap and skip from ptr=3.
      add(4'b0100, 1'b1, 4'b0100);
      add(4'b0101, 1'b1, 4'b0001); add(4'b0101, 1'b1, 4'b0100); add(4'b0101, 1'b1, 4'b0001);
      for (int i = 0; i < 5; i++) add(4'b0000, 1'b1, 4'b0000);
      // arb_en dropped with two accesses in flight, then resumed from held ptr=3.
      add(4'b1111, 1'b1, 4'b0010); add(4'b1111, 1'b1, 4'b0100);
      for (int i = 0; i < 6; i++) add(4'b1111, 1'b0, 4'b0000);
      add(4'b1111, 1'b1, 4'b1000);
      for (int i = 0; i < 5; i++) add(4'b0000, 1'b1, 4'b0000);
      // Single requester held: granted every cycle.
      add(4'b0100, 1'b1, 4'b0100); add(4'b0100, 1'b1, 4'b0100); add(4'b0100, 1'b1, 4'b0100);
      // Three grants left in flight for the reset sequence below.
      add(4'b1111, 1'b1, 4'b1000); add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0010);

      for (int k = 0; k < tbl.size(); k++) begin
         tick(1'b0, tbl[k].r, tbl[k].a, mkaddr(k), tbl[k].eg, $sformatf("vec%0d", k));
      end

      // Reset mid-operation: in-flight responses are dropped, ptr restarts at 0.
      tick(1'b1, 4'b0110, 1'b1, mkaddr(100), '0, "rst_mid");
      tick(1'b1, 4'b0110, 1'b1, mkaddr(101), '0, "rst_mid");
      tick(1'b0, 4'b0110, 1'b1, mkaddr(102), 4'b0010, "post_rst");
      tick(1'b0, 4'b0110, 1'b1, mkaddr(103), 4'b0100, "post_rst");
      for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1, '0, '0, "final_drain");

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d outstanding, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lookup_arbiter.md
Name: lookup_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one fixed-latency lookup table between NREQ requesters in the GPS clock datapath (digit decode, time-zone offset, display scan).
- Accepts at most one request per cycle, drives the shared table address port, and tracks each in-flight access with a requester tag.
- Returns each result only to the requester that issued it, in issue order.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, lookup address width
DW, 8, lookup data width
LAT, 2, lookup read latency in cycles from lk_en to valid lk_data (1..4)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
arb_en  in  1  1 = new grants allowed; 0 = no new grants, in-flight accesses still complete
req  in  NREQ  per-requester request, held high until granted
addr  in  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW]
gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req
lk_en  out  1  lookup read strobe
lk_addr  out  AW  lookup address
lk_data  in  DW  lookup read data, valid LAT cycles after lk_en
rsp_valid  out  NREQ  one-hot response strobe, registered
rsp_data  out  DW  response data, registered, shared by all requesters
busy  out  1  1 while any access is in flight or lk_en is high

Behaviour:
- Reset (async assert, sync release): ptr=0, tag pipeline cleared, lk_en=0, lk_addr=0, rsp_valid=0, rsp_data=0, busy=0. Any in-flight access is dropped; no response is ever issued for it.
- Arbitration (combinational): gnt = first set bit of req, searching from ptr upward and wrapping modulo NREQ. Gated to 0 when arb_en=0 or rst=1. At most one gnt bit is high.
- Handshake: a request is accepted in the cycle that req[i] & gnt[i] are both high. The requester may then drop req or present a new addr; a held req is eligible again the next cycle.
- Pointer: after a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue: on the edge after acceptance, lk_en <= 1 and lk_addr <= addr[i]. With no acceptance, lk_en <= 0 and lk_addr holds its value.
- Tag pipeline: LAT+1 stages of {valid, index}, loaded at issue and shifted every cycle. It never stalls, so throughput is one access per cycle.
- Response: when the final stage is valid, on the next edge rsp_valid[idx] <= 1 and rsp_data <= lk_data. Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: gnt in cycle t -> lk_en in t+1 -> rsp_valid in t+2+LAT (t+4 at default).
- Ordering: responses come back in grant order, and every accepted request yields exactly one response.
- arb_en deasserted mid-stream: in-flight responses are still delivered and busy falls after the last one. Reasserting arb_en resumes from the held ptr.
- Single requester holding req continuously: granted every cycle.
- All NREQ requesting continuously: strict rotation; each requester waits at most NREQ-1 cycles.
- busy = lk_en | any tag stage valid | any rsp_valid bit high.

Test Plan:
- Reset then idle: rst pulsed for 3 cycles, req=0 -> gnt, lk_en, rsp_valid and busy all 0; lk_addr=0 throughout.
- Single access: req=4'b0010, addr[1]=8'h3C, table returns addr^8'hFF -> gnt=0010 in cycle t; lk_en=1 with lk_addr=3C in t+1; rsp_valid=0010 with rsp_data=C3 in t+4.
- Round-robin fairness: req=4'b1111 held for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses follow the same order, each 4 cycles after its grant.
- Wrap and skip: ptr=3, req=4'b0101 -> grant 0 then 2, then 0 again next.
- arb_en low mid-burst: with 2 accesses in flight, arb_en=0 -> no new gnt; both responses delivered at their scheduled cycles; busy falls one cycle after the last rsp_valid.
- Reset mid-operation: rst asserted with 3 accesses in flight -> rsp_valid stays 0 through and after reset, ptr=0 on release, first post-reset grant goes to the lowest requesting index.
